div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle controller for the iterative 32-bit MIPS divider used by DIV/DIVU in the execute stage. It captures operands when a divide enters E and runs a restoring shift-subtract sequence, one quotient bit per cycle. While the sequence runs it drives the E-stage stall that the hazard unit fans out to F/D/E. It delivers HI/LO for one cycle when done, and aborts immediately on an exception flush.

## Interface
- `WIDTH`, 32: operand width; the iteration count equals `WIDTH`.
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  divide instruction valid in E (DIV or DIVU).
- `sign`  in  1  1 = DIV (signed), 0 = DIVU.
- `cancel`  in  1  exception flush from M; aborts any operation.
- `a`  in  WIDTH  dividend (rs); sampled only on the accept cycle.
- `b`  in  WIDTH  divisor (rt); sampled only on the accept cycle.
- `div_stall`  out  1  stall request to the hazard unit (combinational).
- `result_valid`  out  1  HI/LO valid; one-cycle pulse.
- `hi`  out  WIDTH  remainder; registered, holds until the next result.
- `lo`  out  WIDTH  quotient; registered, holds until the next result.
- `busy`  out  1  state is BUSY.

## Operation
- States: IDLE, BUSY, DONE. Reset (asynchronous) clears all registers: state=IDLE, counter=0, hi=0, lo=0, result_valid=0.
- **IDLE**
  - An accept occurs when start=1 and cancel=0.
  - On accept, latch |a|, |b|, sign, a[31]^b[31], a[31], and the raw a.
  - Absolute values are taken only when sign=1. Unsigned operands pass through unchanged.
  - Clear the remainder (WIDTH+1 bits) and counter; go to BUSY.
- **BUSY**
  - Each cycle: {rem,quo} shifts left by 1.
  - If the shifted rem >= |b|: rem -= |b| and quo[0]=1.
  - The counter increments. At counter==WIDTH-1, go to DONE.
- **DONE**
  - Apply the sign fix: lo = -quo if sign & (a[31]^b[31]); hi = -rem if sign & a[31].
  - Divide by zero overrides the result: b==0 gives lo=all-ones and hi=raw a, for both signed and unsigned.
  - Signed 0x80000000 / -1 gives lo=0x80000000, hi=0; no trap.
  - result_valid=1. Go to IDLE unconditionally; start is ignored in DONE, so the held instruction is not re-issued.
- div_stall = (IDLE & start & ~cancel) | BUSY. It is 0 in DONE, which releases the pipeline in the same cycle HI/LO become valid.
- cancel=1 in any state: the next state is IDLE, div_stall=0 in that cycle, no result is written, and hi/lo keep their old values.
- cancel and DONE in the same cycle: cancel wins; result_valid=0 and hi/lo are not updated.
- A start asserted in the first IDLE cycle after DONE is a new instruction and is accepted.

## Timing
- Accept at cycle t (IDLE): BUSY on t+1..t+WIDTH, DONE at t+WIDTH+1.
- div_stall is high on cycles t..t+WIDTH (33 cycles for WIDTH=32).
- result_valid is high only at t+WIDTH+1. hi/lo are visible from the register at t+WIDTH+2 and hold thereafter.
- The minimum gap between back-to-back divides is one IDLE cycle after DONE.
- No combinational path from a/b to any output. div_stall depends combinationally only on start, cancel and state.

## Configuration
- Macro: `DIV_FASTPATH_EN`.
- **Defined:** on accept, if b==0, or if |a| < |b| (compared unsigned on absolute values), skip BUSY and go directly to DONE.
  - Divide by zero produces the override result.
  - The |a| < |b| case gives lo=0 and hi=raw a.
  - div_stall is high only on the accept cycle, so total latency is 2 cycles.
- **Not defined:** every divide takes the full WIDTH iterations. Results are bit-identical with or without the macro.

## Test plan
- DIVU a=100, b=7 -> div_stall high for 33 cycles; result_valid pulse with lo=14, hi=2.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero:
  - DIV a=5, b=0 -> lo=0xFFFFFFFF, hi=5.
  - With `DIV_FASTPATH_EN`, stall lasts 1 cycle and the result is valid at t+1.
- Cancel during BUSY:
  - Setup: hi/lo hold a prior result. Accept at t, cancel at t+10.
  - Required: div_stall=0 at t+10, IDLE at t+11, no result_valid, hi/lo unchanged.
- Back-to-back DIVU 9/3 then DIVU 10/4, with start held through DONE:
  - The first result is lo=3, hi=0. The second accept occurs in the IDLE cycle after DONE, not in DONE.
  - The second result is lo=2, hi=2.
- resetn asserted mid-BUSY -> immediately IDLE, div_stall=0, hi=lo=0, result_valid=0.

Source files
------------

// File: rtl/div_sequencer_if.sv
// Handshake and result bundle between the E-stage divide issue logic and div_sequencer.
interface div_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             sign;
    logic             cancel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             div_stall;
    logic             result_valid;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;

    modport master (
        output start, sign, cancel, a, b,
        input  div_stall, result_valid, hi, lo, busy
    );

    modport slave (
        input  start, sign, cancel, a, b,
        output div_stall, result_valid, hi, lo, busy
    );
endinterface

// File: rtl/div_sequencer.sv
// Iterative restoring divider controller for MIPS DIV/DIVU (one quotient bit per cycle).
// Optional macro DIV_FASTPATH_EN: divide-by-zero and |a| < |b| skip the iteration loop.
module div_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input logic           clk,
    input logic           resetn,
    div_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] abs_b_q;
    logic [WIDTH-1:0] a_raw;
    logic             sign_q;
    logic             neg_q;
    logic             b_zero;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             accept;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             sub_ok;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    // Magnitudes are only taken for signed divides
    assign abs_a  = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign abs_b  = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign accept = (state == IDLE) && bus.start && !bus.cancel;

    // One restoring step: borrow out of the (WIDTH+1)-bit subtract means rem < |b|
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, abs_b_q};
        sub_ok  = !diff[WIDTH];
    end

    // Sign fix-up and divide-by-zero override applied when leaving DONE
    always_comb begin
        fix_lo = (sign_q && neg_q) ? -quo : quo;
        fix_hi = (sign_q && a_raw[WIDTH-1]) ? -rem : rem;
        if (b_zero) begin
            fix_lo = '1;
            fix_hi = a_raw;
        end
    end

`ifdef DIV_FASTPATH_EN
    logic fast;
    assign fast = (bus.b == '0) || (abs_a < abs_b);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            counter <= '0;
            rem     <= '0;
            quo     <= '0;
            abs_b_q <= '0;
            a_raw   <= '0;
            sign_q  <= 1'b0;
            neg_q   <= 1'b0;
            b_zero  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (bus.cancel) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        quo     <= abs_a;
                        rem     <= '0;
                        abs_b_q <= abs_b;
                        a_raw   <= bus.a;
                        sign_q  <= bus.sign;
                        neg_q   <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        b_zero  <= (bus.b == '0);
                        counter <= '0;
                        state   <= BUSY;
`ifdef DIV_FASTPATH_EN
                        if (fast) begin
                            quo   <= '0;
                            rem   <= abs_a;
                            state <= DONE;
                        end
`endif
                    end
                end
                BUSY: begin
                    rem     <= sub_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo     <= {quo[WIDTH-2:0], sub_ok};
                    counter <= counter + CNT_W'(1);
                    if (counter == LAST_CNT) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    hi_q  <= fix_hi;
                    lo_q  <= fix_lo;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stall drops in DONE so the pipeline resumes as HI/LO are written
    assign bus.div_stall    = !bus.cancel && (((state == IDLE) && bus.start) || (state == BUSY));
    assign bus.result_valid = (state == DONE) && !bus.cancel;
    assign bus.busy         = (state == BUSY);
    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: directed cases plus randomized DIV/DIVU against an arithmetic model.
module tb_div_sequencer;
    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } res_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    div_sequencer_if #(.WIDTH(W)) bus ();

    div_sequencer #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    res_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        if (b == '0) begin
            r.lo = '1;
            r.hi = a;
        end else if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                r.lo = 32'h8000_0000;
                r.hi = '0;
            end else begin
                r.lo = W'($signed(a) / $signed(b));
                r.hi = W'($signed(a) % $signed(b));
            end
        end else begin
            r.lo = a / b;
            r.hi = a % b;
        end
        return r;
    endfunction

    function automatic int exp_stall(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_FASTPATH_EN
        logic [W-1:0] ua;
        logic [W-1:0] ub;
        ua = (sgn && a[W-1]) ? -a : a;
        ub = (sgn && b[W-1]) ? -b : b;
        if (b == '0 || ua < ub) return 1;
`endif
        return W + 1;
    endfunction

    // Drive a new divide; only divides expected to complete enter the scoreboard
    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        res_t r;
        bus.start = 1'b1;
        bus.sign  = sgn;
        bus.a     = a;
        bus.b     = b;
        if (push) begin
            r = model(sgn, a, b);
            exp_q.push_back(r);
            last_hi = r.hi;
            last_lo = r.lo;
        end
    endtask

    task automatic count_stall(input bit hold, output int n);
        n = 0;
        #1;
        while (bus.div_stall === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
            if (!hold) bus.start = 1'b0;
            #1;
        end
    endtask

    task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        issue(sgn, a, b, 1'b1);
        count_stall(1'b0, n);
        check("stall_cycles", W'(n), W'(exp_stall(sgn, a, b)));
        @(negedge clk);
    endtask

    // Monitor: result_valid marks DONE, registered HI/LO are checked one cycle later
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            #2;
            if (bus.result_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=valid required=none");
                end else begin
                    r = exp_q.pop_front();
                    @(negedge clk);
                    #2;
                    check("hi", bus.hi, r.hi);
                    check("lo", bus.lo, r.lo);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bus.start  = 1'b0;
        bus.sign   = 1'b0;
        bus.cancel = 1'b0;
        bus.a      = '0;
        bus.b      = '0;

        @(negedge clk);
        #1;
        check("rst_result_valid", W'(bus.result_valid), '0);
        check("rst_div_stall", W'(bus.div_stall), '0);
        check("rst_busy", W'(bus.busy), '0);
        check("rst_hi", bus.hi, '0);
        check("rst_lo", bus.lo, '0);
        resetn = 1'b1;
        @(negedge clk);

        run_div(1'b0, 32'd100, 32'd7);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div(1'b1, 32'd5, 32'd0);
        run_div(1'b0, 32'hDEAD_BEEF, 32'd0);
        run_div(1'b0, 32'd3, 32'd10);
        run_div(1'b1, 32'hFFFF_FFFD, 32'd10);

        // Cancel during BUSY: accept at t, flush at t+10
        issue(1'b0, 32'd1000, 32'd3, 1'b0);
        #1;
        check("cancel_accept_stall", W'(bus.div_stall), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.cancel = 1'b1;
        #1;
        check("cancel_stall_low", W'(bus.div_stall), '0);
        @(negedge clk);
        bus.cancel = 1'b0;
        #1;
        check("cancel_idle", W'(bus.busy), '0);
        check("cancel_hi_hold", bus.hi, last_hi);
        check("cancel_lo_hold", bus.lo, last_lo);
        repeat (3) @(negedge clk);
        #1;
        check("cancel_no_restart", W'(bus.div_stall), '0);
        @(negedge clk);

        // Cancel coinciding with DONE
        issue(1'b0, 32'd1000, 32'd3, 1'b0);
        count_stall(1'b0, n);
        bus.cancel = 1'b1;
        #1;
        check("cancel_done_valid", W'(bus.result_valid), '0);
        @(negedge clk);
        bus.cancel = 1'b0;
        #1;
        check("cancel_done_hi", bus.hi, last_hi);
        check("cancel_done_lo", bus.lo, last_lo);
        @(negedge clk);

        // Back-to-back with start held through DONE
        issue(1'b0, 32'd9, 32'd3, 1'b1);
        count_stall(1'b1, n);
        check("b2b_first_stall", W'(n), W'(exp_stall(1'b0, 32'd9, 32'd3)));
        @(negedge clk);
        issue(1'b0, 32'd10, 32'd4, 1'b1);
        #1;
        check("b2b_idle_busy", W'(bus.busy), '0);
        check("b2b_idle_stall", W'(bus.div_stall), 32'd1);
        count_stall(1'b0, n);
        check("b2b_second_stall", W'(n), W'(exp_stall(1'b0, 32'd10, 32'd4)));
        @(negedge clk);

        // Reset asserted mid-BUSY
        issue(1'b0, 32'd77, 32'd5, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("mid_rst_busy", W'(bus.busy), '0);
        check("mid_rst_stall", W'(bus.div_stall), '0);
        check("mid_rst_valid", W'(bus.result_valid), '0);
        check("mid_rst_hi", bus.hi, '0);
        check("mid_rst_lo", bus.lo, '0);
        last_hi = '0;
        last_lo = '0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        repeat (40) begin
            case ($urandom % 4)
                0: ra = $urandom;
                1: ra = 32'h8000_0000;
                2: ra = W'($urandom % 100);
                default: ra = -W'($urandom % 100);
            endcase
            case ($urandom % 6)
                0: rb = '0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = W'($urandom % 16);
                3: rb = $urandom;
                4: rb = $urandom >> ($urandom % 31);
                default: rb = 32'd1;
            endcase
            run_div(1'($urandom % 2), ra, rb);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", W'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
